// File: rtl/counter_updown_mod_if.sv
// Bundle of the counter's control inputs and count outputs.
// Clock and reset stay outside the interface as plain ports.
//   master : drives CLR, DCLR, LD, D, EN, UP; observes Q, notQ, TC, overflow, underflow
//   slave  : the counter itself
interface counter_updown_mod_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  CLR;
    logic [DATA_WIDTH-1:0] DCLR;
    logic                  LD;
    logic [DATA_WIDTH-1:0] D;
    logic                  EN;
    logic                  UP;
    logic [DATA_WIDTH-1:0] Q;
    logic [DATA_WIDTH-1:0] notQ;
    logic                  TC;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output CLR, DCLR, LD, D, EN, UP,
        input  Q, notQ, TC, overflow, underflow
    );

    modport slave (
        input  CLR, DCLR, LD, D, EN, UP,
        output Q, notQ, TC, overflow, underflow
    );
endinterface

// File: rtl/counter_updown_mod.sv
// Synchronous up/down modulo counter with clear, parallel load, enable,
// programmable modulus and registered wrap pulses.
// Ports:
//   C      rising-edge clock
//   RST_n  asynchronous active-low reset
//   bus    counter_updown_mod_if.slave (CLR/DCLR/LD/D/EN/UP in,
//          Q/notQ/TC/overflow/underflow out)
// Optional build macro COUNTER_UPDOWN_MOD_CASCADE_EN adds CI (carry in,
// gates the enable and TC) and CO (= TC, feeds the next stage's CI).
// Action priority on each edge: clear, then load, then count.
module counter_updown_mod #(
    parameter int              DATA_WIDTH = 4,
    parameter longint unsigned MODULUS    = 16,
    parameter int              CLEAR_VAL  = 1
) (
    input  logic                C,
    input  logic                RST_n,
    counter_updown_mod_if.slave bus
`ifdef COUNTER_UPDOWN_MOD_CASCADE_EN
    ,
    input  logic                CI,
    output logic                CO
`endif
);

    // Largest legal count; all arithmetic wraps here rather than at 2^DATA_WIDTH.
    localparam logic [DATA_WIDTH-1:0] Q_MAX  = DATA_WIDTH'(MODULUS - 64'd1);
    localparam logic                  CLR_LV = (CLEAR_VAL != 0);

    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  en_eff;
    logic                  at_max;
    logic                  at_zero;
    logic                  clr_act;

    // Out-of-range clear/load values saturate to the top of the range so Q
    // can never leave 0..MODULUS-1.
    function automatic logic [DATA_WIDTH-1:0] clip(input logic [DATA_WIDTH-1:0] v);
        return (64'(v) >= MODULUS) ? Q_MAX : v;
    endfunction

`ifdef COUNTER_UPDOWN_MOD_CASCADE_EN
    assign en_eff = bus.EN & CI;
`else
    assign en_eff = bus.EN;
`endif

    assign at_max  = (q_q == Q_MAX);
    assign at_zero = (q_q == '0);
    assign clr_act = (bus.CLR == CLR_LV);

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (clr_act) begin
            q_d = clip(bus.DCLR);
        end else if (bus.LD) begin
            q_d = clip(bus.D);
        end else if (en_eff) begin
            if (bus.UP) begin
                if (at_max) begin
                    q_d   = '0;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q_q + DATA_WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    q_d   = Q_MAX;
                    unf_d = 1'b1;
                end else begin
                    q_d = q_q - DATA_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge C or negedge RST_n) begin
        if (!RST_n) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.notQ      = ~q_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    // Raised in the cycle before a wrap, so a following stage counts on the same edge.
    assign bus.TC        = en_eff & ((bus.UP & at_max) | (~bus.UP & at_zero));

`ifdef COUNTER_UPDOWN_MOD_CASCADE_EN
    assign CO = bus.TC;
`endif

endmodule
